// File: rtl/edge_evt_pkg.sv
// Shared encodings for the edge-event arbiter: edge-select configuration and
// event polarity values.
package edge_evt_pkg;

   typedef enum logic [1:0] {
      EDGE_OFF  = 2'b00,
      EDGE_RISE = 2'b01,
      EDGE_FALL = 2'b10,
      EDGE_BOTH = 2'b11
   } edge_sel_e;

   localparam logic POL_RISE = 1'b1;
   localparam logic POL_FALL = 1'b0;

   function automatic logic rise_enabled(input logic [1:0] sel);
      return (sel == EDGE_RISE) || (sel == EDGE_BOTH);
   endfunction

   function automatic logic fall_enabled(input logic [1:0] sel);
      return (sel == EDGE_FALL) || (sel == EDGE_BOTH);
   endfunction

endpackage

// File: rtl/edge_sync_chan.sv
// One input channel: multi-flop synchroniser, previous-level register and
// edge detectors gated by the channel's edge-select configuration.
module edge_sync_chan
   import edge_evt_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sig_in,
   input  logic [1:0] edge_sel,
   output logic       rise,
   output logic       fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_out;
   logic                   prev_q;

   assign sync_out = sync_q[SYNC_STAGES-1];

   // NOTE: every flop uses <= so the chain advances exactly one stage per clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
         prev_q <= sync_out;
      end
   end

   assign rise = sync_out & ~prev_q & rise_enabled(edge_sel);
   assign fall = ~sync_out & prev_q & fall_enabled(edge_sel);

endmodule

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event controller: per-channel pending events with sticky
// overflow, serialised by a round-robin arbiter onto one valid/ready stream.
module edge_event_arbiter
   import edge_evt_pkg::*;
#(
   parameter  int NUM_CH      = 4,
   parameter  int SYNC_STAGES = 2,
   localparam int CH_W        = $clog2(NUM_CH)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_CH-1:0]   sig_in,
   input  logic [2*NUM_CH-1:0] edge_sel,
   output logic                evt_valid,
   input  logic                evt_ready,
   output logic [CH_W-1:0]     evt_ch,
   output logic                evt_pol,
   output logic [NUM_CH-1:0]   pending,
   output logic [NUM_CH-1:0]   overflow,
   input  logic [NUM_CH-1:0]   ovf_clr
);

   logic [NUM_CH-1:0] rise;
   logic [NUM_CH-1:0] fall;
   logic [NUM_CH-1:0] edge_det;
   logic [NUM_CH-1:0] pend_pol;
   logic [NUM_CH-1:0] ovf_set;
   logic [NUM_CH-1:0] grant_vec;
   logic [NUM_CH-1:0] pend_rot;
   logic [CH_W-1:0]   rr_ptr;
   logic [CH_W-1:0]   start;
   logic [CH_W-1:0]   grant_off;
   logic [CH_W-1:0]   grant_ch;
   logic [CH_W:0]     grant_sum;
   logic              grant_hit;
   logic              load;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
      edge_sync_chan #(
         .SYNC_STAGES (SYNC_STAGES)
      ) u_chan (
         .clk      (clk),
         .rst_n    (rst_n),
         .sig_in   (sig_in[i]),
         .edge_sel (edge_sel[2*i +: 2]),
         .rise     (rise[i]),
         .fall     (fall[i])
      );
   end

   assign edge_det = rise | fall;
   assign load     = !evt_valid || evt_ready;

   // Rotate so the channel after rr_ptr sits at bit 0, pick the lowest set
   // bit, then map the offset back to an absolute channel index.
   // NOTE: every output gets a default first, so no path can infer a latch.
   always_comb begin
      start     = (rr_ptr == CH_W'(NUM_CH - 1)) ? '0 : rr_ptr + CH_W'(1);
      pend_rot  = NUM_CH'({pending, pending} >> start);
      grant_off = '0;
      grant_hit = 1'b0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (pend_rot[k]) begin
            grant_off = CH_W'(k);
            grant_hit = 1'b1;
         end
      end
      grant_sum = {1'b0, start} + {1'b0, grant_off};
      if (grant_sum >= (CH_W+1)'(NUM_CH)) begin
         grant_ch = CH_W'(grant_sum - (CH_W+1)'(NUM_CH));
      end else begin
         grant_ch = grant_sum[CH_W-1:0];
      end
      grant_vec = '0;
      if (load && grant_hit) begin
         grant_vec[grant_ch] = 1'b1;
      end
   end

   // An edge is lost only if the old event stays pending through this cycle.
   assign ovf_set = edge_det & pending & ~grant_vec;

   // NOTE: pend_pol is reset as well; it is only read behind pending, but this
   // leaves no undefined state after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending  <= '0;
         pend_pol <= '0;
         overflow <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (edge_det[i] && !ovf_set[i]) begin
               pending[i]  <= 1'b1;
               pend_pol[i] <= rise[i] ? POL_RISE : POL_FALL;
            end else if (grant_vec[i]) begin
               pending[i]  <= 1'b0;
            end
         end
         overflow <= (overflow & ~ovf_clr) | ovf_set;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_valid <= 1'b0;
         evt_ch    <= '0;
         evt_pol   <= POL_FALL;
         rr_ptr    <= CH_W'(NUM_CH - 1);
      end else if (load) begin
         if (grant_hit) begin
            evt_valid <= 1'b1;
            evt_ch    <= grant_ch;
            evt_pol   <= pend_pol[grant_ch];
            rr_ptr    <= grant_ch;
         end else begin
            evt_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic, all compared
// cycle by cycle against a behavioural model of the event controller.
module tb_edge_event_arbiter;
   import edge_evt_pkg::*;

   localparam int NUM_CH      = 4;
   localparam int SYNC_STAGES = 2;
   localparam int CH_W        = 2;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [NUM_CH-1:0]   sig_in;
   logic [2*NUM_CH-1:0] edge_sel;
   logic                evt_valid;
   logic                evt_ready;
   logic [CH_W-1:0]     evt_ch;
   logic                evt_pol;
   logic [NUM_CH-1:0]   pending;
   logic [NUM_CH-1:0]   overflow;
   logic [NUM_CH-1:0]   ovf_clr;

   edge_event_arbiter #(
      .NUM_CH      (NUM_CH),
      .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sig_in    (sig_in),
      .edge_sel  (edge_sel),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_ch    (evt_ch),
      .evt_pol   (evt_pol),
      .pending   (pending),
      .overflow  (overflow),
      .ovf_clr   (ovf_clr)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Behavioural model: sampled-input history, pending/overflow flags, slot.
   logic [NUM_CH-1:0] hist [SYNC_STAGES+1];
   bit m_pend [NUM_CH];
   bit m_ppol [NUM_CH];
   bit m_ovf  [NUM_CH];
   bit m_valid;
   bit m_pol;
   int m_ch;
   int m_rr;
   int acc [$];

   task automatic model_reset();
      for (int s = 0; s <= SYNC_STAGES; s++) hist[s] = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         m_pend[i] = 0;
         m_ppol[i] = 0;
         m_ovf[i]  = 0;
      end
      m_valid = 0;
      m_pol   = 0;
      m_ch    = 0;
      m_rr    = NUM_CH - 1;
   endtask

   task automatic model_step();
      logic [NUM_CH-1:0] cur, prv;
      logic [1:0] sel;
      bit r, f, ev, lost, ld, g_pol;
      int g, c;
      // The level seen by the detector now was sampled SYNC_STAGES edges ago.
      cur = hist[SYNC_STAGES-1];
      prv = hist[SYNC_STAGES];
      ld  = !m_valid || evt_ready;
      g   = -1;
      if (ld) begin
         for (int k = 1; k <= NUM_CH; k++) begin
            c = (m_rr + k) % NUM_CH;
            if (m_pend[c]) begin
               g = c;
               break;
            end
         end
      end
      g_pol = (g >= 0) ? m_ppol[g] : 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         sel  = edge_sel[2*i +: 2];
         r    = cur[i] && !prv[i] && (sel == EDGE_RISE || sel == EDGE_BOTH);
         f    = !cur[i] && prv[i] && (sel == EDGE_FALL || sel == EDGE_BOTH);
         ev   = r || f;
         lost = ev && m_pend[i] && (i != g);
         if (!lost && ev) begin
            m_pend[i] = 1;
            m_ppol[i] = r;
         end else if (!lost && i == g) begin
            m_pend[i] = 0;
         end
         if (lost) m_ovf[i] = 1;
         else if (ovf_clr[i]) m_ovf[i] = 0;
      end
      if (ld) begin
         if (g >= 0) begin
            m_valid = 1;
            m_ch    = g;
            m_pol   = g_pol;
            m_rr    = g;
         end else begin
            m_valid = 0;
         end
      end
      for (int s = SYNC_STAGES; s >= 1; s--) hist[s] = hist[s-1];
      hist[0] = sig_in;
   endtask

   task automatic compare();
      logic [NUM_CH-1:0] mp, mo;
      for (int i = 0; i < NUM_CH; i++) begin
         mp[i] = m_pend[i];
         mo[i] = m_ovf[i];
      end
      check("evt_valid", evt_valid, m_valid);
      if (m_valid) begin
         check("evt_ch", evt_ch, m_ch);
         check("evt_pol", evt_pol, m_pol);
      end
      check("pending", pending, mp);
      check("overflow", overflow, mo);
   endtask

   task automatic tick();
      bit fire;
      int fch;
      fire = evt_valid && evt_ready && rst_n;
      fch  = evt_ch;
      @(posedge clk);
      if (rst_n) model_step();
      #1;
      if (fire) acc.push_back(fch);
      compare();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bit hold_valid, hold_pol;
      int hold_ch;

      rst_n     = 1'b0;
      sig_in    = '0;
      edge_sel  = '0;
      evt_ready = 1'b0;
      ovf_clr   = '0;
      model_reset();
      #12;
      check("rst_valid", evt_valid, 0);
      check("rst_ch", evt_ch, 0);
      check("rst_pol", evt_pol, 0);
      check("rst_pending", pending, 0);
      check("rst_overflow", overflow, 0);
      rst_n = 1'b1;
      ticks(3);

      // 1: single rising edge on ch0, latency counted in sampling edges.
      edge_sel  = 8'b0000_0001;
      sig_in[0] = 1'b1;
      n = 0;
      while (!evt_valid && n < 10) begin
         tick();
         n++;
      end
      check("t1_latency_edges", n, 4);
      check("t1_ch", evt_ch, 0);
      check("t1_pol", evt_pol, 1);
      evt_ready = 1'b1;
      tick();
      check("t1_pending_after", pending, 0);
      check("t1_valid_after", evt_valid, 0);

      // 2: simultaneous edges on ch1 and ch3, round-robin order, twice.
      for (int rep = 0; rep < 2; rep++) begin
         evt_ready = 1'b0;
         edge_sel  = 8'hFF;
         acc.delete();
         sig_in = sig_in ^ 4'b1010;
         ticks(5);
         evt_ready = 1'b1;
         ticks(3);
         check("t2_count", acc.size(), 2);
         if (acc.size() == 2) begin
            check("t2_first", acc[0], 1);
            check("t2_second", acc[1], 3);
         end
      end

      // 3: repeated edges on ch2 while pending -> overflow, then clearing.
      evt_ready = 1'b0;
      edge_sel  = 8'b0011_0000;
      sig_in[2] = ~sig_in[2];
      ticks(4);
      sig_in[2] = ~sig_in[2];
      ticks(3);
      sig_in[2] = ~sig_in[2];
      ticks(3);
      check("t3_pending2", pending[2], 1);
      check("t3_overflow2", overflow[2], 1);
      ovf_clr = 4'b0100;
      tick();
      ovf_clr = '0;
      check("t3_ovf_cleared", overflow[2], 0);
      sig_in[2] = ~sig_in[2];
      ticks(2);
      ovf_clr = 4'b0100;
      tick();
      ovf_clr = '0;
      check("t3_set_wins", overflow[2], 1);

      // 4: stalled slot holds while other inputs are randomised.
      hold_valid = m_valid;
      hold_ch    = m_ch;
      hold_pol   = m_pol;
      check("t4_slot_full", evt_valid, 1);
      for (int i = 0; i < 20; i++) begin
         sig_in   = NUM_CH'($urandom);
         edge_sel = 8'($urandom);
         ovf_clr  = NUM_CH'($urandom);
         tick();
         check("t4_hold_valid", evt_valid, hold_valid);
         check("t4_hold_ch", evt_ch, hold_ch);
         check("t4_hold_pol", evt_pol, hold_pol);
      end
      ovf_clr   = '0;
      evt_ready = 1'b1;
      tick();
      check("t4_reload_valid", evt_valid, 1);
      edge_sel = '0;
      ticks(8);

      // 5: rise-only config; cfg change while pending keeps the event.
      evt_ready = 1'b0;
      sig_in    = 4'b0001;
      ticks(4);
      edge_sel = 8'b0000_0001;
      acc.delete();
      sig_in[0] = 1'b0;
      ticks(4);
      check("t5_fall_ignored", evt_valid, 0);
      sig_in[0] = 1'b1;
      ticks(4);
      check("t5_rise_valid", evt_valid, 1);
      check("t5_rise_ch", evt_ch, 0);
      check("t5_rise_pol", evt_pol, 1);
      sig_in[0] = 1'b0;
      ticks(3);
      sig_in[0] = 1'b1;
      ticks(4);
      check("t5_pending0", pending[0], 1);
      edge_sel  = '0;
      evt_ready = 1'b1;
      ticks(4);
      check("t5_delivered", acc.size(), 2);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 2) == 0) sig_in[$urandom_range(0, NUM_CH-1)] ^= 1'b1;
         if (i % 50 == 0) edge_sel = 8'($urandom);
         evt_ready = 1'($urandom_range(0, 1));
         ovf_clr   = ($urandom_range(0, 7) == 0) ? NUM_CH'($urandom) : '0;
         tick();
      end
      ovf_clr   = '0;
      edge_sel  = '0;
      evt_ready = 1'b1;
      ticks(8);

      // 6: reset mid-transfer, then release with sig_in[0] high.
      evt_ready = 1'b0;
      edge_sel  = 8'hFF;
      sig_in    = sig_in ^ 4'b1110;
      ticks(5);
      check("t6_valid_before", evt_valid, 1);
      check("t6_pending_count", $countones(pending), 2);
      sig_in   = 4'b0001;
      edge_sel = 8'b0000_0001;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("t6_rst_valid", evt_valid, 0);
      check("t6_rst_ch", evt_ch, 0);
      check("t6_rst_pol", evt_pol, 0);
      check("t6_rst_pending", pending, 0);
      check("t6_rst_overflow", overflow, 0);
      ticks(2);
      #3;
      rst_n = 1'b1;
      n = 0;
      while (!evt_valid && n < 10) begin
         tick();
         n++;
      end
      check("t6_latency_edges", n, 4);
      check("t6_ch", evt_ch, 0);
      check("t6_pol", evt_pol, 1);
      acc.delete();
      evt_ready = 1'b1;
      ticks(6);
      check("t6_single_event", acc.size(), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
